// File: rtl/conv_feeder_pkg.sv
// -----------------------------------------------------------------------------
// conv_feeder_pkg
// Shared definitions for the convolution feeder: FSM state encoding, default
// widths/lengths, and helpers that size pointers and buffer addresses.
// -----------------------------------------------------------------------------
package conv_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_READY  = 2'd2,
        ST_STREAM = 2'd3
    } feeder_state_e;

    localparam int DEF_IFM_DATA_WIDTH = 8;
    localparam int DEF_WGT_WIDTH      = 72;
    localparam int DEF_IFM_LENGTH     = 12288;
    localparam int DEF_WGT_LENGTH     = 24;

    // Pointers and counters must be able to hold the value LENGTH itself,
    // because "pointer == LENGTH" is how a full buffer / finished stream is seen.
    function automatic int ptr_width(input int length);
        return $clog2(length + 1);
    endfunction

    // Address width of a buffer of the given depth (never below one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_IFM_PTR_W = ptr_width(DEF_IFM_LENGTH);
    localparam int DEF_WGT_PTR_W = ptr_width(DEF_WGT_LENGTH);

endpackage

// File: rtl/conv_feeder_buf.sv
// -----------------------------------------------------------------------------
// feeder_buf
// Simple storage array: synchronous write, asynchronous (combinational) read.
// No reset; contents are undefined until written.
//   clk1   : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module feeder_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk1,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk1) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/conv_feeder.sv
// -----------------------------------------------------------------------------
// conv_feeder
// Loads an IFM frame and a weight frame into two local buffers, then streams
// them to a convolution accelerator on demand.
//   clk1        : sole clock
//   rst         : asynchronous active-high reset
//   load_valid  : load beat present
//   load_sel    : 0 = IFM buffer, 1 = weight buffer
//   load_data   : load beat (IFM uses the low IFM_DATA_WIDTH bits)
//   load_ready  : load beat accepted this cycle
//   go          : start a pass (honoured only when both buffers are full)
//   start_conv  : one-cycle start pulse to the accelerator
//   ifm_read    : accelerator IFM fetch strobe
//   wgt_read    : accelerator weight fetch strobe
//   ifm / wgt   : data answering the fetch strobes in the same cycle
//   busy        : pass in progress
//   done        : one-cycle pulse at pass end
//   err         : sticky over-read flag
//
// Load handshake: a beat transfers on a rising edge where load_valid and
// load_ready are both 1. load_ready is combinational from the current state,
// load_sel and the selected buffer's fill level; the producer holds the beat
// stable until it is accepted. IDLE and READY never accept a beat: they only
// move to LOAD, and the held beat is taken on the following cycle.
// -----------------------------------------------------------------------------
module conv_feeder
    import conv_feeder_pkg::*;
#(
    parameter int IFM_DATA_WIDTH = DEF_IFM_DATA_WIDTH,
    parameter int WGT_WIDTH      = DEF_WGT_WIDTH,
    parameter int IFM_LENGTH     = DEF_IFM_LENGTH,
    parameter int WGT_LENGTH     = DEF_WGT_LENGTH
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      load_valid,
    input  logic                      load_sel,
    input  logic [WGT_WIDTH-1:0]      load_data,
    output logic                      load_ready,
    input  logic                      go,
    output logic                      start_conv,
    input  logic                      ifm_read,
    input  logic                      wgt_read,
    output logic [IFM_DATA_WIDTH-1:0] ifm,
    output logic [WGT_WIDTH-1:0]      wgt,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int IFM_PW = ptr_width(IFM_LENGTH);
    localparam int WGT_PW = ptr_width(WGT_LENGTH);
    localparam int IFM_AW = addr_width(IFM_LENGTH);
    localparam int WGT_AW = addr_width(WGT_LENGTH);

    localparam logic [IFM_PW-1:0] IFM_FULL = IFM_PW'(IFM_LENGTH);
    localparam logic [WGT_PW-1:0] WGT_FULL = WGT_PW'(WGT_LENGTH);
    localparam logic [IFM_PW-1:0] IFM_ONE  = IFM_PW'(1);
    localparam logic [WGT_PW-1:0] WGT_ONE  = WGT_PW'(1);

    feeder_state_e state_q, state_d;

    logic [IFM_PW-1:0] ifm_ptr_q, ifm_ptr_d;
    logic [WGT_PW-1:0] wgt_ptr_q, wgt_ptr_d;
    logic [IFM_PW-1:0] ifm_cnt_q, ifm_cnt_d;
    logic [WGT_PW-1:0] wgt_cnt_q, wgt_cnt_d;
    // Set once a stream counter has reached LENGTH during the current pass.
    logic              ifm_seen_q, ifm_seen_d;
    logic              wgt_seen_q, wgt_seen_d;
    logic              err_q, err_d;

    logic                      ifm_we, wgt_we;
    logic [IFM_DATA_WIDTH-1:0] ifm_rdata;
    logic [WGT_WIDTH-1:0]      wgt_rdata;

    logic ifm_full, wgt_full, ifm_end, wgt_end, pass_end;

    assign ifm_full = (ifm_ptr_q == IFM_FULL);
    assign wgt_full = (wgt_ptr_q == WGT_FULL);
    assign ifm_end  = (ifm_cnt_q == IFM_FULL);
    assign wgt_end  = (wgt_cnt_q == WGT_FULL);
    // The pass ends in the first cycle where both streams have been exhausted
    // at least once; a stream that already wrapped still counts as finished.
    assign pass_end = (state_q == ST_STREAM) &&
                      (ifm_seen_q || ifm_end) && (wgt_seen_q || wgt_end);

    feeder_buf #(
        .WIDTH (IFM_DATA_WIDTH),
        .DEPTH (IFM_LENGTH),
        .ADDR_W(IFM_AW)
    ) u_ifm_buf (
        .clk1 (clk1),
        .we   (ifm_we),
        .waddr(ifm_ptr_q[IFM_AW-1:0]),
        .wdata(load_data[IFM_DATA_WIDTH-1:0]),
        .raddr(ifm_cnt_q[IFM_AW-1:0]),
        .rdata(ifm_rdata)
    );

    feeder_buf #(
        .WIDTH (WGT_WIDTH),
        .DEPTH (WGT_LENGTH),
        .ADDR_W(WGT_AW)
    ) u_wgt_buf (
        .clk1 (clk1),
        .we   (wgt_we),
        .waddr(wgt_ptr_q[WGT_AW-1:0]),
        .wdata(load_data),
        .raddr(wgt_cnt_q[WGT_AW-1:0]),
        .rdata(wgt_rdata)
    );

    always_comb begin
        state_d    = state_q;
        ifm_ptr_d  = ifm_ptr_q;
        wgt_ptr_d  = wgt_ptr_q;
        ifm_cnt_d  = ifm_cnt_q;
        wgt_cnt_d  = wgt_cnt_q;
        ifm_seen_d = ifm_seen_q;
        wgt_seen_d = wgt_seen_q;
        err_d      = err_q;
        load_ready = 1'b0;
        ifm_we     = 1'b0;
        wgt_we     = 1'b0;
        start_conv = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (load_valid) begin
                    if (!load_sel && !ifm_full) begin
                        load_ready = 1'b1;
                        ifm_we     = 1'b1;
                        ifm_ptr_d  = ifm_ptr_q + IFM_ONE;
                    end else if (load_sel && !wgt_full) begin
                        load_ready = 1'b1;
                        wgt_we     = 1'b1;
                        wgt_ptr_d  = wgt_ptr_q + WGT_ONE;
                    end
                end
                if (ifm_full && wgt_full) begin
                    state_d = ST_READY;
                end
            end

            ST_READY: begin
                if (go) begin
                    start_conv = 1'b1;
                    ifm_cnt_d  = '0;
                    wgt_cnt_d  = '0;
                    ifm_seen_d = 1'b0;
                    wgt_seen_d = 1'b0;
                    state_d    = ST_STREAM;
                end else if (load_valid) begin
                    // Reloading one buffer restarts only that buffer's fill.
                    state_d = ST_LOAD;
                    if (load_sel) begin
                        wgt_ptr_d = '0;
                    end else begin
                        ifm_ptr_d = '0;
                    end
                end
            end

            ST_STREAM: begin
                // Exhausted counter: a strobe is an over-read (hold, flag it);
                // an idle cycle wraps to 0 so weights can be fetched again.
                if (ifm_read) begin
                    if (!ifm_end) begin
                        ifm_cnt_d = ifm_cnt_q + IFM_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ifm_end) begin
                    ifm_cnt_d = '0;
                end

                if (wgt_read) begin
                    if (!wgt_end) begin
                        wgt_cnt_d = wgt_cnt_q + WGT_ONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (wgt_end) begin
                    wgt_cnt_d = '0;
                end

                ifm_seen_d = ifm_seen_q | ifm_end;
                wgt_seen_d = wgt_seen_q | wgt_end;

                if (pass_end) begin
                    done    = 1'b1;
                    state_d = ST_READY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ifm_ptr_q  <= '0;
            wgt_ptr_q  <= '0;
            ifm_cnt_q  <= '0;
            wgt_cnt_q  <= '0;
            ifm_seen_q <= 1'b0;
            wgt_seen_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ifm_ptr_q  <= ifm_ptr_d;
            wgt_ptr_q  <= wgt_ptr_d;
            ifm_cnt_q  <= ifm_cnt_d;
            wgt_cnt_q  <= wgt_cnt_d;
            ifm_seen_q <= ifm_seen_d;
            wgt_seen_q <= wgt_seen_d;
            err_q      <= err_d;
        end
    end

    assign busy = (state_q == ST_STREAM);
    assign err  = err_q;
    assign ifm  = (busy && ifm_read && !ifm_end) ? ifm_rdata : '0;
    assign wgt  = (busy && wgt_read && !wgt_end) ? wgt_rdata : '0;

endmodule

// File: tb/tb_conv_feeder.sv
module tb_conv_feeder;

    localparam int IW          = 8;
    localparam int WW          = 72;
    localparam int IL          = 12288;
    localparam int WL          = 24;
    localparam int PASS_BUDGET = 20000;
    localparam logic [WW-1:0] WGT_PATTERN = 72'h010203010203010203;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_sel;
    logic [WW-1:0] load_data;
    logic          load_ready;
    logic          go;
    logic          start_conv;
    logic          ifm_read;
    logic          wgt_read;
    logic [IW-1:0] ifm;
    logic [WW-1:0] wgt;
    logic          busy;
    logic          done;
    logic          err;

    conv_feeder #(
        .IFM_DATA_WIDTH(IW),
        .WGT_WIDTH     (WW),
        .IFM_LENGTH    (IL),
        .WGT_LENGTH    (WL)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .load_valid(load_valid),
        .load_sel  (load_sel),
        .load_data (load_data),
        .load_ready(load_ready),
        .go        (go),
        .start_conv(start_conv),
        .ifm_read  (ifm_read),
        .wgt_read  (wgt_read),
        .ifm       (ifm),
        .wgt       (wgt),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // ---------------- clock ----------------
    always #5 clk1 = ~clk1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Buffers as plain arrays, stream positions as integers, pass progress
    // as "has this stream been exhausted yet" flags.
    logic [IW-1:0] m_ifm [IL];
    logic [WW-1:0] m_wgt [WL];
    int  m_ifm_ptr = 0;
    int  m_wgt_ptr = 0;
    int  m_icnt    = 0;
    int  m_wcnt    = 0;
    bit  m_iseen   = 1'b0;
    bit  m_wseen   = 1'b0;
    bit  m_err     = 1'b0;

    typedef struct {
        logic          lv;
        logic          sel;
        logic          g;
        logic [WW-1:0] data;
        logic          exp_lr;
        logic          exp_sc;
        logic          exp_busy;
    } ctl_vec_t;

    ctl_vec_t vecs [5];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_write(input logic sel, input logic [WW-1:0] d);
        if (sel) begin
            if (m_wgt_ptr < WL) begin
                m_wgt[m_wgt_ptr] = d;
                m_wgt_ptr++;
            end
        end else begin
            if (m_ifm_ptr < IL) begin
                m_ifm[m_ifm_ptr] = d[IW-1:0];
                m_ifm_ptr++;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_load_ready"}, load_ready, 1'b0);
        check1({tag, "_start_conv"}, start_conv, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        checkw({tag, "_ifm"}, {{(WW-IW){1'b0}}, ifm}, '0);
        checkw({tag, "_wgt"}, wgt, '0);
    endtask

    // ---------------- driver tasks ----------------
    // One load beat with handshake: held until accepted, bounded retries.
    task automatic load_beat(input logic sel, input logic [WW-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) begin
            @(negedge clk1);
            load_valid = 1'b1;
            load_sel   = sel;
            load_data  = d;
            #1;
            acc = load_ready;
            @(posedge clk1);
            #1;
            load_valid = 1'b0;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL load_accept: beat sel=%b not accepted within 4 cycles", sel);
        end else begin
            model_write(sel, d);
        end
    endtask

    task automatic apply_vec(input ctl_vec_t v, input int idx);
        @(negedge clk1);
        load_valid = v.lv;
        load_sel   = v.sel;
        load_data  = v.data;
        go         = v.g;
        #1;
        check1($sformatf("vec%0d_load_ready", idx), load_ready, v.exp_lr);
        check1($sformatf("vec%0d_start_conv", idx), start_conv, v.exp_sc);
        check1($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
        if (v.exp_lr) begin
            model_write(v.sel, v.data);
        end
        @(posedge clk1);
        #1;
        go         = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic do_go(input bit exp_start);
        @(negedge clk1);
        go = 1'b1;
        #1;
        check1("start_conv_on_go", start_conv, exp_start);
        check1("busy_on_go", busy, 1'b0);
        @(posedge clk1);
        #1;
        go = 1'b0;
        @(negedge clk1);
        #1;
        check1("start_conv_single_pulse", start_conv, 1'b0);
        check1("busy_after_go", busy, exp_start);
        if (exp_start) begin
            m_icnt  = 0;
            m_wcnt  = 0;
            m_iseen = 1'b0;
            m_wseen = 1'b0;
        end
    endtask

    // One streaming cycle: drive strobes, compare against the model, advance it.
    task automatic stream_cycle(input bit ir, input bit wr, output bit d);
        logic [IW-1:0] ei;
        logic [WW-1:0] ew;
        logic          ed;
        @(negedge clk1);
        ifm_read = ir;
        wgt_read = wr;
        #1;
        ei = (ir && m_icnt < IL) ? m_ifm[m_icnt] : '0;
        ew = (wr && m_wcnt < WL) ? m_wgt[m_wcnt] : '0;
        ed = (m_iseen || m_icnt == IL) && (m_wseen || m_wcnt == WL);
        checkw("ifm", {{(WW-IW){1'b0}}, ifm}, {{(WW-IW){1'b0}}, ei});
        checkw("wgt", wgt, ew);
        check1("done", done, ed);
        check1("busy_stream", busy, 1'b1);
        check1("err", err, m_err);
        check1("start_conv_stream", start_conv, 1'b0);
        if (m_icnt == IL) m_iseen = 1'b1;
        if (m_wcnt == WL) m_wseen = 1'b1;
        if (ir) begin
            if (m_icnt < IL) m_icnt++;
            else m_err = 1'b1;
        end else if (m_icnt == IL) begin
            m_icnt = 0;
        end
        if (wr) begin
            if (m_wcnt < WL) m_wcnt++;
            else m_err = 1'b1;
        end else if (m_wcnt == WL) begin
            m_wcnt = 0;
        end
        d = ed;
    endtask

    // mode 0: IFM read straight through, weights read twice with a gap
    // mode 1: IFM read held past the end (over-read), weights read once
    // mode 2: random strobes
    task automatic run_pass(input int mode);
        bit d;
        bit ir;
        bit wr;
        int k;
        d = 1'b0;
        k = 0;
        while (!d && k < PASS_BUDGET) begin
            case (mode)
                0: begin
                    ir = (k < IL);
                    wr = (k < WL) || (k >= WL + 1 && k < 2 * WL + 1);
                end
                1: begin
                    ir = 1'b1;
                    wr = (k < WL);
                end
                default: begin
                    ir = ($urandom_range(0, 15) != 0);
                    wr = ($urandom_range(0, 1) == 1);
                end
            endcase
            stream_cycle(ir, wr, d);
            k++;
        end
        n_checks++;
        if (!d) begin
            n_fail++;
            $display("FAIL pass_done: mode %0d no done pulse within %0d cycles", mode, PASS_BUDGET);
        end
        if (mode == 0) begin
            n_checks++;
            if (k != IL + 1) begin
                n_fail++;
                $display("FAIL done_cycle: done after %0d cycles, expected %0d", k, IL + 1);
            end
        end
        @(negedge clk1);
        ifm_read = 1'b0;
        wgt_read = 1'b0;
        #1;
        check1("busy_after_done", busy, 1'b0);
        check1("done_single_pulse", done, 1'b0);
        check1("err_after_done", err, m_err);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit dummy;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_sel   = 1'b0;
        load_data  = '0;
        go         = 1'b0;
        ifm_read   = 1'b0;
        wgt_read   = 1'b0;

        repeat (2) @(posedge clk1);
        #1;
        check_all_zero("reset");
        @(negedge clk1);
        rst = 1'b0;

        // 24 weight words
        for (int i = 0; i < WL; i++) begin
            load_beat(1'b1, WGT_PATTERN);
        end

        // Control corners while IFM is still empty/partial
        vecs[0] = '{lv: 1'b1, sel: 1'b1, g: 1'b0, data: {WW{1'b1}},
                    exp_lr: 1'b0, exp_sc: 1'b0, exp_busy: 1'b0};   // 25th weight beat
        vecs[1] = '{lv: 1'b0, sel: 1'b0, g: 1'b1, data: '0,
                    exp_lr: 1'b0, exp_sc: 1'b0, exp_busy: 1'b0};   // go while loading
        vecs[2] = '{lv: 1'b1, sel: 1'b0, g: 1'b1, data: 72'd0,
                    exp_lr: 1'b1, exp_sc: 1'b0, exp_busy: 1'b0};   // IFM beat 0 + go
        vecs[3] = '{lv: 1'b1, sel: 1'b0, g: 1'b0, data: 72'd1,
                    exp_lr: 1'b1, exp_sc: 1'b0, exp_busy: 1'b0};   // IFM beat 1
        vecs[4] = '{lv: 1'b0, sel: 1'b0, g: 1'b1, data: '0,
                    exp_lr: 1'b0, exp_sc: 1'b0, exp_busy: 1'b0};   // go again, ignored
        for (int i = 0; i < 5; i++) begin
            apply_vec(vecs[i], i);
        end

        for (int i = 2; i < IL; i++) begin
            load_beat(1'b0, WW'(i % 256));
        end
        @(negedge clk1);

        // Pass 1: in-order IFM, weights twice with a wrap gap
        do_go(1'b1);
        run_pass(0);

        // Pass 2: replay without reload, IFM over-read at the end
        do_go(1'b1);
        run_pass(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            ifm_read = 1'b1;
            #1;
            check1("err_sticky", err, m_err);
            check1("err_sticky_expected_set", m_err, 1'b1);
            checkw("ifm_after_pass", {{(WW-IW){1'b0}}, ifm}, '0);
        end
        ifm_read = 1'b0;

        // Pass 3: random strobes
        do_go(1'b1);
        run_pass(2);

        // Pass 4: reset in the middle of streaming
        do_go(1'b1);
        for (int i = 0; i < 5000; i++) begin
            stream_cycle(1'b1, ($urandom_range(0, 1) == 1), dummy);
        end
        @(negedge clk1);
        ifm_read = 1'b1;
        wgt_read = 1'b1;
        rst      = 1'b1;
        #1;
        m_ifm_ptr = 0;
        m_wgt_ptr = 0;
        m_icnt    = 0;
        m_wcnt    = 0;
        m_err     = 1'b0;
        check_all_zero("abort");
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        rst      = 1'b0;
        ifm_read = 1'b0;
        wgt_read = 1'b0;

        // go after reset without reload must not start a pass
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            go = 1'b1;
            #1;
            check1("post_reset_start_conv", start_conv, 1'b0);
            check1("post_reset_busy", busy, 1'b0);
            check1("post_reset_err", err, m_err);
        end
        go = 1'b0;
        @(negedge clk1);
        #1;
        check1("post_reset_done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameter IFM_DATA_WIDTH, default 8: width of one IFM element.
REQ-002 Parameter WGT_WIDTH, default 72: width of one weight word (3x3 kernel of 8-bit taps).
REQ-003 Parameter IFM_LENGTH, default 12288: IFM elements per frame (64*64*3).
REQ-004 Parameter WGT_LENGTH, default 24: weight words per frame (3 channels * 8 kernels).
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 clk1  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous reset, active-high.
REQ-008 load_valid  in  1  load beat present.
REQ-009 load_sel  in  1  0 = IFM buffer, 1 = weight buffer.
REQ-010 load_data  in  WGT_WIDTH  load beat; IFM loads use bits [IFM_DATA_WIDTH-1:0].
REQ-011 load_ready  out  1  load beat accepted this cycle.
REQ-012 go  in  1  request to start a convolution pass.
REQ-013 start_conv  out  1  one-cycle start pulse to the accelerator.
REQ-014 ifm_read  in  1  accelerator IFM fetch strobe.
REQ-015 wgt_read  in  1  accelerator weight fetch strobe.
REQ-016 ifm  out  IFM_DATA_WIDTH  IFM element answering ifm_read.
REQ-017 wgt  out  WGT_WIDTH  weight word answering wgt_read.
REQ-018 busy  out  1  pass in progress.
REQ-019 done  out  1  one-cycle pulse at pass end.
REQ-020 err  out  1  sticky over-read flag.

Function
REQ-021 FSM states: IDLE, LOAD, READY, STREAM; encoding in package.
REQ-022 IDLE->LOAD on first load_valid; LOAD accepts beats (load_ready=1) into the selected buffer at its own load pointer, incrementing by one per accepted beat.
REQ-023 A beat to a full buffer (pointer == LENGTH) SHALL be rejected (load_ready=0), data discarded.
REQ-024 LOAD->READY when both load pointers equal their LENGTH.
REQ-025 READY with go=1: start_conv=1 for exactly one cycle, ifm_cnt/wgt_cnt cleared to 0, state->STREAM, busy=1 from the next cycle.
REQ-026 go outside READY SHALL be ignored.
REQ-027 In STREAM, ifm = ifm_buf[ifm_cnt] combinationally in the same cycle ifm_read=1; ifm = 0 when ifm_read=0. wgt/wgt_read/wgt_cnt identical.
REQ-028 ifm_cnt increments on each clk1 edge with ifm_read=1 and ifm_cnt < IFM_LENGTH; holds otherwise. wgt_cnt likewise.
REQ-029 Counter == LENGTH with read=0: counter wraps to 0 next edge (supports re-fetch of weights per channel group).
REQ-030 Read strobe with counter == LENGTH: output 0, counter holds, err set and held until reset.
REQ-031 ifm_read and wgt_read simultaneously are legal and serviced independently.
REQ-032 Pass end: first cycle both counters have reached LENGTH at least once since start_conv; done pulses one cycle, busy drops, state->READY with buffers retained (new go restarts without reload).
REQ-033 load_valid in READY returns to LOAD, clearing the targeted buffer's load pointer; in STREAM load_ready=0.

Reset
REQ-034 rst=1 asynchronously: state IDLE; load pointers, ifm_cnt, wgt_cnt = 0; ifm, wgt, start_conv, busy, done, err, load_ready = 0. Buffer contents undefined.
REQ-035 Reset mid-STREAM aborts the pass; no done pulse; after release a full reload is required before go is honoured.

Structure
REQ-036 Shared package holds the FSM state typedef, default lengths/widths, and pointer-width constants (clog2(LENGTH+1)).
REQ-037 One sub-module, feeder_buf (parameterised width/depth, synchronous write, asynchronous read), instantiated twice for IFM and weight buffers.

Verification
REQ-038 Load 12288 IFM bytes i%256 and 24 weight words 72'h010203010203010203, go -> start_conv single pulse, then ifm_read held 12288 cycles returns 0,1,2,...,255,0... in order.
REQ-039 wgt_read 24 cycles -> wgt = 72'h010203010203010203 each cycle; wgt_read low one cycle -> wgt_cnt wraps to 0; 24 more reads repeat the sequence.
REQ-040 Both streams complete -> done one pulse, busy 0, second go without reload replays identical data.
REQ-041 ifm_read held after 12288 reads -> ifm=0, ifm_cnt holds 12288, err=1 and stays 1 until rst.
REQ-042 rst asserted at IFM read 5000 -> all outputs 0 immediately, state IDLE; go after release with no reload -> no start_conv.
REQ-043 25th weight load beat -> load_ready=0, buffer unchanged; go before IFM load complete -> ignored.
